// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between NREQ requesters
// (0 = instruction fetch, 1 = load/store unit, 2 = debug/program loader).
// Requesters are served round-robin with one transaction in flight at a
// time. The memory answers a fixed LAT cycles after its access strobe.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        per-requester request level, held until granted
//   i_we         per-requester write enable, valid with i_req
//   i_addr       packed addresses, slice i = [i*AW +: AW]
//   i_wdata      packed write data, slice i = [i*DW +: DW]
//   o_gnt        one-hot grant, one-cycle pulse
//   o_done       one-hot completion, one-cycle pulse
//   o_rdata      read data, valid with a done pulse of a read, else 0
//   o_busy       transaction in flight
//   o_memEn      memory access strobe
//   o_memWe      memory write strobe
//   o_memAddr    memory address
//   o_memWData   memory write data
//   i_memRData   memory read data, valid LAT cycles after the strobe
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LAT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_we,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic [DW-1:0]      o_rdata,
  output logic               o_busy,
  output logic               o_memEn,
  output logic               o_memWe,
  output logic [AW-1:0]      o_memAddr,
  output logic [DW-1:0]      o_memWData,
  input  logic [DW-1:0]      i_memRData
);

  localparam int PW = $clog2(NREQ);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  logic          r_state;
  logic [PW-1:0] r_rrPtr;
  logic [PW-1:0] r_owner;
  logic          r_ownerWe;
  logic [2:0]    r_cnt;

  logic [2*NREQ-1:0] w_reqDbl;
  logic [NREQ-1:0]   w_reqRot;
  logic              w_any;
  logic [PW-1:0]     w_win;
  logic [PW:0]       w_sum;
  logic [PW-1:0]     w_nextPtr;
  logic              w_grant;
  logic              w_doneNow;

  // Rotate the request vector so that bit 0 is the requester at r_rrPtr;
  // the first set bit of the rotated vector is then the round-robin winner.
  assign w_reqDbl = {i_req, i_req} >> r_rrPtr;
  assign w_reqRot = w_reqDbl[NREQ-1:0];

  // Map the rotated position back to a requester index modulo NREQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && w_reqRot[k]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_rrPtr} + (PW+1)'(k);
        if (w_sum >= (PW+1)'(NREQ)) begin
          w_sum = w_sum - (PW+1)'(NREQ);
        end
        w_win = w_sum[PW-1:0];
      end
    end
  end

  assign w_nextPtr = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;

  // Outputs are gated with i_rst_n so they drop to zero the instant reset
  // asserts, even though the grant path is combinational from i_req.
  assign w_grant   = i_rst_n && (r_state == S_IDLE) && w_any;
  assign w_doneNow = i_rst_n && (r_state == S_WAIT) && (r_cnt == 3'd1);

  assign o_gnt      = w_grant ? (NREQ'(1) << w_win) : '0;
  assign o_memEn    = w_grant;
  assign o_memWe    = w_grant && i_we[w_win];
  assign o_memAddr  = w_grant ? i_addr[w_win*AW +: AW] : '0;
  assign o_memWData = w_grant ? i_wdata[w_win*DW +: DW] : '0;

  assign o_busy  = i_rst_n && (r_state == S_WAIT);
  assign o_done  = w_doneNow ? (NREQ'(1) << r_owner) : '0;
  // Writes complete with rdata held at zero; only reads pass memory data.
  assign o_rdata = (w_doneNow && !r_ownerWe) ? i_memRData : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rrPtr   <= '0;
      r_owner   <= '0;
      r_ownerWe <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_win;
            r_ownerWe <= i_we[w_win];
            r_rrPtr   <= w_nextPtr;
            r_cnt     <= 3'(LAT);
            r_state   <= S_WAIT;
          end
        end
        default: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous memory of the MIPS-subset core between NREQ requesters: instruction fetch, load/store unit, and a debug/program loader.
- Round-robin arbitration, one outstanding transaction at a time, with a fixed memory read latency.
- Requesters see a req/gnt/done handshake. The memory sees a plain enable/write-enable port.
- Sits between cpu2's fetch and data paths and the unified memory macro.

Parameters:
NREQ, 3, number of requesters (2..8); index 0 = fetch, 1 = data, 2 = loader
AW, 32, address width
DW, 32, data width
LAT, 1, memory read latency in cycles (1..4); applied uniformly to reads and writes

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  request per requester; level, held until gnt
we  input  NREQ  write enable per requester; valid with req
addr  input  NREQ*AW  packed addresses; slice i = requester i
wdata  input  NREQ*DW  packed write data
gnt  output  NREQ  one-hot grant; one-cycle pulse
done  output  NREQ  one-hot completion; one-cycle pulse
rdata  output  DW  read data, valid when any done bit is set for a read
busy  output  1  transaction in flight
memEn  output  1  memory access strobe
memWe  output  1  memory write strobe
memAddr  output  AW  memory address
memWData  output  DW  memory write data
memRData  input  DW  memory read data, valid LAT cycles after the strobe cycle

Behaviour:
- Reset: rst_n low immediately forces the state to IDLE, rrPtr=0, cnt=0, and owner=0. All outputs go to 0 regardless of req, including gnt, done, busy, memEn and memWe.
- Reset mid-transaction abandons it. No done pulse is ever issued for the abandoned transaction.
- States: IDLE and WAIT.
- IDLE:
  - If any req bit is set, winner w = first set bit searching upward from rrPtr with wrap (rrPtr, rrPtr+1, …, NREQ-1, 0, …).
  - In the same cycle (combinational from registered state and req): gnt[w]=1, memEn=1, memWe=we[w], memAddr=addr slice w, memWData=wdata slice w.
  - At the clock edge: owner<=w, rrPtr<=(w+1) mod NREQ, cnt<=LAT, state<=WAIT.
  - With no req set, all outputs are 0.
- WAIT:
  - busy=1, gnt=0, memEn=0.
  - cnt decrements each cycle.
  - In the cycle where cnt==1: done[owner]=1 and rdata=memRData (pass-through). At the edge, state<=IDLE.
  - rdata=0 in every cycle without a done bit.
- Timing for a grant in cycle t:
  - done in t+LAT.
  - busy high t+1..t+LAT.
  - Earliest next grant t+LAT+1.
  - Peak throughput one access per LAT+1 cycles.
- Writes: the memory commits at the edge closing cycle t. done still pulses at t+LAT. rdata is don't-care, and is driven 0 for writes.
- Requester rules:
  - addr, we and wdata must be stable while req is high and before gnt. They are sampled only in the gnt cycle.
  - Deasserting req before gnt withdraws the request with no side effects.
  - req still high in the cycle after done counts as a new request.
  - Requests arriving during WAIT are not granted until IDLE.
- Fairness: a continuously requesting master waits at most (NREQ-1)*(LAT+1) cycles between grants.
- Simultaneous events: done and a new gnt never share a cycle. Only one gnt bit is ever set.
- Widths: index slice i = bits [i*AW +: AW] and [i*DW +: DW]. rrPtr and owner are clog2(NREQ) bits wide. cnt is 3 bits.

Test Plan:
1. LAT=1; reset; mem[0x40]=0x1234ABCD; req[1]=1, we=0, addr=0x40 at cycle 0 -> gnt=3'b010 and memEn=1 at cycle 0; done=3'b010 and rdata=0x1234ABCD at cycle 1; gnt=0 at cycle 1.
2. LAT=1; req=3'b111 held continuously from reset release -> gnt order 0,1,2,0,1 at cycles 0,2,4,6,8; each done one cycle after its gnt.
3. LAT=1; req[2] write 0xDEADBEEF to 0x10, then req[2] read 0x10 -> read done returns 0xDEADBEEF; memWe=1 only in the write's gnt cycle.
4. LAT=3; single req[0] read at cycle t -> done at t+3; busy high t+1..t+3; second queued req[1] granted at t+4.
5. rst_n pulsed low in the first WAIT cycle of a read by req[1] -> all outputs 0 asynchronously; no done afterwards. After release with req=3'b011, req[0] is granted first (rrPtr=0).
6. req[1] raised during WAIT and dropped before IDLE, with req[0] held -> req[1] never granted; req[0] granted at the next IDLE cycle.
